exec_sequencer: RTL

//  Multi-cycle control sequencer for the Harvard CPU datapath. Steps each

---
 rtl/cpu_seq_pkg.sv | 20 ++
 rtl/exec_sequencer_if.sv | 47 ++++
 rtl/exec_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the multi-cycle execution sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_seq_pkg;

  // Sequencer states, one per instruction phase.
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    MDWAIT,
    WB,
    HALTED
  } seq_state_t;

  // Number of cycles a MULT/DIV occupies the ALU before HI/LO are written.
  localparam int DEFAULT_MULDIV_CYCLES = 32;

endpackage

// File: rtl/exec_sequencer_if.sv
// Handshake and strobe bundle between the sequencer, the decoder and the datapath.
// Latency: none (wires only).
// Backpressure: instr_waitrequest and data_waitrequest stall the requests that are open.
//
// Ports (master = sequencer side):
//   in : pc_is_zero, instr_waitrequest, data_waitrequest, is_load, is_store,
//        is_muldiv, reg_write_req
//   out: active, instr_read, data_read, data_write, ir_en, mdr_en, pc_en,
//        reg_write_en, hilo_write_en, muldiv_start
interface exec_sequencer_if;

  // Status and handshake inputs to the sequencer
  logic pc_is_zero;
  logic instr_waitrequest;
  logic data_waitrequest;
  logic is_load;
  logic is_store;
  logic is_muldiv;
  logic reg_write_req;

  // Requests and write-enable strobes from the sequencer
  logic active;
  logic instr_read;
  logic data_read;
  logic data_write;
  logic ir_en;
  logic mdr_en;
  logic pc_en;
  logic reg_write_en;
  logic hilo_write_en;
  logic muldiv_start;

  modport master (
    input  pc_is_zero, instr_waitrequest, data_waitrequest,
    input  is_load, is_store, is_muldiv, reg_write_req,
    output active, instr_read, data_read, data_write,
    output ir_en, mdr_en, pc_en, reg_write_en, hilo_write_en, muldiv_start
  );

  modport slave (
    output pc_is_zero, instr_waitrequest, data_waitrequest,
    output is_load, is_store, is_muldiv, reg_write_req,
    input  active, instr_read, data_read, data_write,
    input  ir_en, mdr_en, pc_en, reg_write_en, hilo_write_en, muldiv_start
  );

endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer: FETCH -> EXEC -> (MEM | MDWAIT) -> WB, gating PC/IR/regfile/HI-LO writes.
// Latency (no wait states): ALU 3 cycles, store 3, load 4, MULT/DIV 2 + MULDIV_CYCLES.
// Backpressure: FETCH and MEM hold their request and stall while the matching waitrequest is high.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; forces IDLE and drops every output at once
//   bus   - exec_sequencer_if.master (decoder status in, bus requests and write strobes out)
module exec_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MULDIV_CYCLES = DEFAULT_MULDIV_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  exec_sequencer_if.master   bus
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Access direction latched in EXEC so the MEM-phase requests decode from
  // registered state only; a combined load+store resolves to a store.
  logic             mem_wr_q, mem_wr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    mem_wr_d          = mem_wr_q;
    bus.instr_read    = 1'b0;
    bus.ir_en         = 1'b0;
    bus.data_read     = 1'b0;
    bus.data_write    = 1'b0;
    bus.mdr_en        = 1'b0;
    bus.pc_en         = 1'b0;
    bus.reg_write_en  = 1'b0;
    bus.hilo_write_en = 1'b0;
    bus.muldiv_start  = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        // The PC is stable for the whole FETCH phase, so a zero PC is
        // caught before any read goes out.
        if (bus.pc_is_zero) begin
          state_d = HALTED;
        end else begin
          bus.instr_read = 1'b1;
          if (!bus.instr_waitrequest) begin
            bus.ir_en = 1'b1;
            state_d   = EXEC;
          end
        end
      end

      EXEC: begin
        if (bus.is_muldiv) begin
          bus.muldiv_start = 1'b1;
          cnt_d            = CNT_LOAD;
          state_d          = MDWAIT;
        end else if (bus.is_store) begin
          mem_wr_d = 1'b1;
          state_d  = MEM;
        end else if (bus.is_load) begin
          mem_wr_d = 1'b0;
          state_d  = MEM;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        bus.data_write = mem_wr_q;
        bus.data_read  = !mem_wr_q;
        if (!bus.data_waitrequest) begin
          if (mem_wr_q) begin
            bus.pc_en = 1'b1;
            state_d   = FETCH;
          end else begin
            bus.mdr_en = 1'b1;
            state_d    = WB;
          end
        end
      end

      MDWAIT: begin
        // Counter enters at MULDIV_CYCLES-1, so the zero cycle is the last of
        // exactly MULDIV_CYCLES cycles here; it never decrements past zero.
        if (cnt_q == '0) begin
          bus.hilo_write_en = 1'b1;
          bus.pc_en         = 1'b1;
          state_d           = FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      WB: begin
        bus.reg_write_en = bus.reg_write_req;
        bus.pc_en        = 1'b1;
        state_d          = FETCH;
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.active = (state_q != IDLE) && (state_q != HALTED);

endmodule
